eth_rx_parser: RTL and testbench

Byte-level Ethernet receive parser sitting directly downstream of `MIIcore`. It consumes the assembled octet stream (`d`/`rdy`/`error`) plus the MII frame-enable and performs four functions:
- strips preamble and SFD;
- captures destination MAC, source MAC and EtherType;
- filters on destination address;
- streams the payload out with the trailing 4-byte FCS removed, and reports a CRC-32 verdict at end of frame.

---
 rtl/eth_rx_parser.sv | 183 ++++++++++++++++++
 tb/tb_eth_rx_parser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_parser.sv
// rtl/eth_rx_parser.sv - Ethernet receive octet parser: preamble strip, header capture, address filter, FCS check
// Sits behind the MII octet assembler and delivers the payload with the FCS trimmed off.

module eth_rx_crc32_byte (
  input  logic [31:0] crc,
  input  logic [7:0]  d,
  output logic [31:0] crc_next
);
  // Reflected CRC-32, octet consumed LSB first.
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++) begin
      if (crc_next[0] ^ d[i]) crc_next = (crc_next >> 1) ^ 32'hEDB88320;
      else                    crc_next = crc_next >> 1;
    end
  end
endmodule

module eth_rx_parser #(
  parameter logic [47:0] MAC_ADDR = 48'h54_ff_01_21_23_24,
  parameter bit          PROMISC  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_d,
  input  logic        in_rdy,
  input  logic        in_error,
  input  logic        in_en,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] eth_type,
  output logic        hdr_valid,
  output logic [7:0]  pay_d,
  output logic        pay_valid,
  output logic [10:0] pay_len,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        frame_err,
  output logic        dropped
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, HDR, PAYLOAD, DROP, DONE} state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_t          state;
  logic [2:0]      pre_cnt;
  logic [3:0]      hdr_cnt;
  logic [3:0][7:0] dly;
  logic [2:0]      dly_cnt;
  logic            err;
  logic            drop_f;
  logic            armed;
  logic [31:0]     crc;
  logic [31:0]     crc_next;

  eth_rx_crc32_byte u_crc (
    .crc      (crc),
    .d        (in_d),
    .crc_next (crc_next)
  );

  logic        in_frame;
  logic        frame_end;
  logic        feed_crc;
  logic        hdr_last;
  logic        reject;
  logic        short_pay;
  logic        final_err;
  logic        final_drop;
  logic [31:0] final_crc;

  // Verdict terms also cover an octet accepted in the same cycle that in_en falls.
  always_comb begin
    in_frame   = (state == PREAMBLE) || (state == HDR) || (state == PAYLOAD) || (state == DROP);
    frame_end  = in_frame && !in_en;
    feed_crc   = in_rdy && ((state == HDR) || (state == PAYLOAD));
    hdr_last   = in_rdy && (state == HDR) && (hdr_cnt == 4'd13);
    reject     = hdr_last && !PROMISC && (dst_mac != MAC_ADDR) && (dst_mac != 48'hFFFF_FFFF_FFFF);
    short_pay  = (state == PAYLOAD) && ((dly_cnt + 3'(in_rdy)) < 3'd4);
    final_err  = err || in_error || (state == PREAMBLE) || (state == HDR) || short_pay;
    final_drop = drop_f || reject;
    final_crc  = feed_crc ? crc_next : crc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      hdr_cnt    <= '0;
      dly        <= '0;
      dly_cnt    <= '0;
      err        <= 1'b0;
      drop_f     <= 1'b0;
      armed      <= 1'b0;
      crc        <= '0;
      dst_mac    <= '0;
      src_mac    <= '0;
      eth_type   <= '0;
      hdr_valid  <= 1'b0;
      pay_d      <= '0;
      pay_valid  <= 1'b0;
      pay_len    <= '0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      frame_err  <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      hdr_valid  <= 1'b0;
      pay_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // armed stays low after a mid-frame reset until the aborted frame ends
          if (!in_en) begin
            armed <= 1'b1;
          end else if (armed) begin
            state   <= PREAMBLE;
            pre_cnt <= '0;
            hdr_cnt <= '0;
            pay_len <= '0;
            dly     <= '0;
            dly_cnt <= '0;
            err     <= 1'b0;
            drop_f  <= 1'b0;
            crc     <= 32'hFFFF_FFFF;
          end
        end
        PREAMBLE: if (in_rdy) begin
          if (in_d == 8'h55) begin
            if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
          end else if (in_d == 8'hD5 && pre_cnt != 3'd0) begin
            state <= HDR;
          end else begin
            err   <= 1'b1;
            state <= DROP;
          end
        end
        HDR: if (in_rdy) begin
          if (hdr_cnt < 4'd6)       dst_mac  <= {dst_mac[39:0], in_d};
          else if (hdr_cnt < 4'd12) src_mac  <= {src_mac[39:0], in_d};
          else                      eth_type <= {eth_type[7:0], in_d};
          crc     <= crc_next;
          hdr_cnt <= hdr_cnt + 4'd1;
          if (hdr_cnt == 4'd13) begin
            hdr_valid <= 1'b1;
            if (reject) begin
              drop_f <= 1'b1;
              state  <= DROP;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: if (in_rdy) begin
          crc <= crc_next;
          dly <= {dly[2:0], in_d};
          // Holding four octets back means the FCS never reaches pay_d.
          if (dly_cnt == 3'd4) begin
            pay_d     <= dly[3];
            pay_valid <= 1'b1;
            if (pay_len != 11'h7FF) pay_len <= pay_len + 11'd1;
          end else begin
            dly_cnt <= dly_cnt + 3'd1;
          end
        end
        DROP: ;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (in_frame) begin
        if (in_error) err <= 1'b1;
        if (frame_end) begin
          state      <= DONE;
          armed      <= 1'b1;
          frame_done <= 1'b1;
          frame_err  <= final_err;
          dropped    <= final_drop;
          crc_ok     <= (final_crc == CRC_RESIDUE) && !final_err && !final_drop;
        end
      end
    end
  end
endmodule

// File: tb/tb_eth_rx_parser.sv
// tb/tb_eth_rx_parser.sv - directed bench for eth_rx_parser with payload scoreboard
// A second instance with PROMISC=1 shares the stimulus.

module tb_eth_rx_parser;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_d;
  logic        in_rdy;
  logic        in_error;
  logic        in_en;

  logic [47:0] dst_mac, src_mac, dst_mac_p, src_mac_p;
  logic [15:0] eth_type, eth_type_p;
  logic        hdr_valid, pay_valid, frame_done, crc_ok, frame_err, dropped;
  logic        hdr_valid_p, pay_valid_p, frame_done_p, crc_ok_p, frame_err_p, dropped_p;
  logic [7:0]  pay_d, pay_d_p;
  logic [10:0] pay_len, pay_len_p;

  localparam logic [47:0] STATION = 48'h54_ff_01_21_23_24;
  localparam logic [47:0] SRC     = 48'h12_34_56_78_9a_bc;
  localparam logic [15:0] ETYPE   = 16'h1234;

  string       pay_s = "Twas' on the good ship Venus...\n";
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          hdr_seen = 0, done_seen = 0, hdr_cyc = 0, done_cyc = 0;
  int          hdr_before = 0, done_before = 0, hdr_drive_cyc = 0, en_drop_cyc = 0;
  logic [47:0] cap_dst, cap_src;
  logic [15:0] cap_type;

  eth_rx_parser dut (
    .clk(clk), .reset(reset), .in_d(in_d), .in_rdy(in_rdy), .in_error(in_error), .in_en(in_en),
    .dst_mac(dst_mac), .src_mac(src_mac), .eth_type(eth_type), .hdr_valid(hdr_valid),
    .pay_d(pay_d), .pay_valid(pay_valid), .pay_len(pay_len), .frame_done(frame_done),
    .crc_ok(crc_ok), .frame_err(frame_err), .dropped(dropped)
  );

  eth_rx_parser #(.PROMISC(1'b1)) dut_p (
    .clk(clk), .reset(reset), .in_d(in_d), .in_rdy(in_rdy), .in_error(in_error), .in_en(in_en),
    .dst_mac(dst_mac_p), .src_mac(src_mac_p), .eth_type(eth_type_p), .hdr_valid(hdr_valid_p),
    .pay_d(pay_d_p), .pay_valid(pay_valid_p), .pay_len(pay_len_p), .frame_done(frame_done_p),
    .crc_ok(crc_ok_p), .frame_err(frame_err_p), .dropped(dropped_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Monitor: payload scoreboard and event capture, sampled on the falling edge.
  initial begin
    logic has;
    forever begin
      @(negedge clk);
      if (pay_valid) begin
        has = (exp_q.size() != 0);
        check("pay_expected", has, 1);
        if (has) check("pay_d", pay_d, exp_q.pop_front());
      end
      if (hdr_valid) begin
        hdr_seen++;
        hdr_cyc  = cyc;
        cap_dst  = dst_mac;
        cap_src  = src_mac;
        cap_type = eth_type;
      end
      if (frame_done) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {hdr_valid, pay_valid, frame_done, crc_ok, frame_err, dropped, pay_len, pay_d}, 0);
    check({tag, "_hdr"}, |{dst_mac, src_mac, eth_type}, 0);
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [7:0] sfd, input int flip_idx,
                            input int err_idx, input int rst_idx, input bit same_end, input bit expect_pay);
    logic [7:0]  b[$];
    logic [31:0] c;
    logic [47:0] s;
    logic [15:0] t;
    int          n_exp;
    s = SRC;
    t = ETYPE;
    hdr_before  = hdr_seen;
    done_before = done_seen;
    for (int i = 0; i < 7; i++) b.push_back(8'h55);
    b.push_back(sfd);
    for (int i = 5; i >= 0; i--) b.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(s[i*8 +: 8]);
    b.push_back(t[15:8]);
    b.push_back(t[7:0]);
    for (int i = 0; i < 32; i++) b.push_back(pay_s[i]);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < b.size(); i++) c = crc_upd(c, b[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) b.push_back(c[i*8 +: 8]);
    if (flip_idx >= 0) b[22+flip_idx] = b[22+flip_idx] ^ 8'h04;
    n_exp = (rst_idx >= 0) ? rst_idx - 4 : 32;
    if (expect_pay) for (int i = 0; i < n_exp; i++) exp_q.push_back(b[22+i]);
    in_en = 1'b1;
    for (int i = 0; i < b.size(); i++) begin
      if (rst_idx >= 0 && i == 22 + rst_idx) begin
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("rst_mid");
        reset = 1'b0;
      end
      in_d   = b[i];
      in_rdy = 1'b1;
      if (err_idx >= 0 && i == 22 + err_idx) in_error = 1'b1;
      if (i == 21) hdr_drive_cyc = cyc;
      if (same_end && i == b.size() - 1) begin
        in_en = 1'b0;
        en_drop_cyc = cyc;
      end
      @(posedge clk); #1;
      in_rdy   = 1'b0;
      in_error = 1'b0;
      @(posedge clk); #1;
    end
    if (!same_end) begin
      in_en = 1'b0;
      en_drop_cyc = cyc;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic verdict(input string tag, input int e_hdr, input int e_done, input bit e_crc,
                         input bit e_err, input bit e_drop, input int e_len);
    check({tag, "_hdr_cnt"}, hdr_seen - hdr_before, e_hdr);
    check({tag, "_done_cnt"}, done_seen - done_before, e_done);
    if (e_hdr == 1) check({tag, "_hdr_lat"}, hdr_cyc, hdr_drive_cyc + 1);
    if (e_done == 1) begin
      check({tag, "_done_lat"}, done_cyc, en_drop_cyc + 1);
      check({tag, "_crc_ok"}, crc_ok, e_crc);
      check({tag, "_frame_err"}, frame_err, e_err);
      check({tag, "_dropped"}, dropped, e_drop);
    end
    check({tag, "_pay_len"}, pay_len, e_len);
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; in_d = '0; in_rdy = 1'b0; in_error = 1'b0; in_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send_frame(STATION, 8'hD5, -1, -1, -1, 1'b0, 1'b1);
    verdict("valid", 1, 1, 1'b1, 1'b0, 1'b0, 32);
    check("valid_dst", cap_dst, STATION);
    check("valid_src", cap_src, SRC);
    check("valid_type", cap_type, ETYPE);

    send_frame(STATION, 8'hD5, 9, -1, -1, 1'b0, 1'b1);
    verdict("bitflip", 1, 1, 1'b0, 1'b0, 1'b0, 32);

    send_frame(48'h00_11_22_33_44_55, 8'hD5, -1, -1, -1, 1'b0, 1'b0);
    verdict("filtered", 1, 1, 1'b0, 1'b0, 1'b1, 0);
    check("filtered_dst", cap_dst, 48'h00_11_22_33_44_55);
    check("promisc_pay_len", pay_len_p, 32);
    check("promisc_dropped", dropped_p, 0);
    check("promisc_crc_ok", crc_ok_p, 1);

    send_frame(48'hFFFF_FFFF_FFFF, 8'hD5, -1, -1, -1, 1'b1, 1'b1);
    verdict("bcast_sameend", 1, 1, 1'b1, 1'b0, 1'b0, 32);

    send_frame(STATION, 8'hD4, -1, -1, -1, 1'b0, 1'b0);
    verdict("bad_sfd", 0, 1, 1'b0, 1'b1, 1'b0, 0);

    send_frame(STATION, 8'hD5, -1, 12, -1, 1'b0, 1'b1);
    verdict("in_error", 1, 1, 1'b0, 1'b1, 1'b0, 32);

    send_frame(STATION, 8'hD5, -1, -1, 20, 1'b0, 1'b1);
    verdict("mid_reset", 1, 0, 1'b0, 1'b0, 1'b0, 0);

    send_frame(STATION, 8'hD5, -1, -1, -1, 1'b0, 1'b1);
    verdict("after_reset", 1, 1, 1'b1, 1'b0, 1'b0, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
